// File: rtl/mem_responder_pkg.sv
// Shared types, funct3 encodings and the access-legality rule for the
// MEM-stage data-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    // Stores allow only B/H/W; loads add BU/HU. Halves need addr[0]=0,
    // words need addr[1:0]=0.
    function automatic logic mode_legal(input logic       write,
                                        input logic [2:0] mode,
                                        input logic [1:0] addr_lo);
        logic ok;
        case (mode)
            MODE_B:  ok = 1'b1;
            MODE_H:  ok = ~addr_lo[0];
            MODE_W:  ok = (addr_lo == 2'b00);
            MODE_BU: ok = ~write;
            MODE_HU: ok = ~write & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Load/store handshake between the MEM stage (master) and the responder (slave).
interface mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [2:0]            req_mode;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_mode,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_mode,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/mem_responder_byte_lane_align.sv
// Little-endian lane steering: extends loaded bytes/halves and merges
// store data into the old word, lanes chosen by the low address bits.
module byte_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mode,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and build both the load result and the merged store word
    always_comb begin
        byte_sel  = word[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? word[31:16] : word[15:0];

        load_data = word;
        case (mode)
            MODE_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            MODE_BU: load_data = {24'h000000, byte_sel};
            MODE_H:  load_data = {{16{half_sel[15]}}, half_sel};
            MODE_HU: load_data = {16'h0000, half_sel};
            default: load_data = word;
        endcase

        store_word = word;
        case (mode)
            MODE_B:  store_word[{addr_lo, 3'b000} +: 8]   = wdata[7:0];
            MODE_H:  store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            MODE_W:  store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency data-memory responder: one access in flight, combinational
// stall toward the pipeline, registered one-cycle response.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    mem_state_t            state;
    logic [3:0]            cnt;
    logic                  ready_r;
    logic                  resp_valid_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  err_r;

    logic                  cap_write;
    logic [IDX_W+1:0]      cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [2:0]            cap_mode;

    logic [DATA_WIDTH-1:0] storage [DEPTH_WORDS];

    logic                  hs;
    logic                  acc_write;
    logic [IDX_W+1:0]      acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [2:0]            acc_mode;
    logic                  acc_legal;
    logic                  do_access;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_word;
    logic [DATA_WIDTH-1:0] rdata_next;
    logic                  addr_hi_unused;

    // Upper address bits wrap the word index and are intentionally dropped.
    assign addr_hi_unused = ^bus.req_addr[31:IDX_W+2];

    assign hs = bus.req_valid & ready_r;

    // With LATENCY==1 the access happens on the accept edge, so the live request is used
    // instead of the not-yet-loaded capture registers.
    always_comb begin
        acc_write = cap_write;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        acc_mode  = cap_mode;
        if (state == IDLE) begin
            acc_write = bus.req_write;
            acc_addr  = bus.req_addr[IDX_W+1:0];
            acc_wdata = bus.req_wdata;
            acc_mode  = bus.req_mode;
        end
    end

    assign acc_legal = mode_legal(acc_write, acc_mode, acc_addr[1:0]);

    // cnt counts the WAIT cycles still to go; the access fires on the edge that takes it to 0.
    assign do_access = ((state == WAIT) && (cnt == 4'd1)) ||
                       ((state == IDLE) && hs && (LATENCY == 1));

    assign mem_we     = do_access & acc_legal & acc_write & rst;
    assign old_word   = storage[acc_addr[IDX_W+1:2]];
    assign rdata_next = (acc_legal && !acc_write) ? load_data : '0;

    byte_lane_align u_align (
        .word       (old_word),
        .wdata      (acc_wdata),
        .addr_lo    (acc_addr[1:0]),
        .mode       (acc_mode),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Storage array: written only on the access edge, never cleared by reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            storage[acc_addr[IDX_W+1:2]] <= store_word;
        end
    end

    // Request FSM with capture registers, latency counter and registered response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            rdata_r      <= '0;
            err_r        <= 1'b0;
            cap_write    <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_mode     <= '0;
        end else begin
            resp_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        cap_write <= bus.req_write;
                        cap_addr  <= bus.req_addr[IDX_W+1:0];
                        cap_wdata <= bus.req_wdata;
                        cap_mode  <= bus.req_mode;
                        cnt       <= 4'(LATENCY - 1);
                        ready_r   <= 1'b0;
                        if (LATENCY == 1) begin
                            state        <= RESP;
                            resp_valid_r <= 1'b1;
                            rdata_r      <= rdata_next;
                            err_r        <= ~acc_legal;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state        <= RESP;
                        resp_valid_r <= 1'b1;
                        rdata_r      <= rdata_next;
                        err_r        <= ~acc_legal;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = rdata_r;
    assign bus.resp_err   = err_r;
    assign bus.stall      = ((state == IDLE) & bus.req_valid) | (state == WAIT);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances at LATENCY 2, 1, 15 and 4
// share the request wires; only the selected instance sees req_valid.
module tb_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_mode  = '0;
    int unsigned sel = 0;

    int n_cmp = 0;
    int n_bad = 0;

    logic        rv   [4];
    logic        rdy  [4];
    logic        erra [4];
    logic        stl  [4];
    logic [31:0] rda  [4];

    always #5 clk = ~clk;

    mem_responder_if #(.DATA_WIDTH(32)) bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign bus[g].req_valid = req_valid && (sel == g);
        assign bus[g].req_write = req_write;
        assign bus[g].req_addr  = req_addr;
        assign bus[g].req_wdata = req_wdata;
        assign bus[g].req_mode  = req_mode;
        assign rv[g]   = bus[g].resp_valid;
        assign rdy[g]  = bus[g].req_ready;
        assign erra[g] = bus[g].resp_err;
        assign stl[g]  = bus[g].stall;
        assign rda[g]  = bus[g].resp_rdata;

        mem_responder #(
            .DATA_WIDTH  (32),
            .DEPTH_WORDS (1024),
            .LATENCY     ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 15 : 4)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );
    end

    function automatic int lat_of(input int unsigned s);
        case (s)
            0:       return 2;
            1:       return 1;
            2:       return 15;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one request on the selected instance, keeps it on the bus until
    // resp_valid, and checks handshake timing, stall profile and response.
    task automatic access(input string tag, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] mode,
                          input logic [31:0] exp_rd, input bit exp_err, input bit hold);
        int k;
        int bad_stall;
        int bad_ready;
        bit seen;
        logic [31:0] got_rd;
        logic got_err;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_mode  = mode;
        #1;
        check({tag, "_ready_idle"}, 32'(rdy[sel]), 32'd1);
        check({tag, "_stall_req"}, 32'(stl[sel]), 32'd1);
        k = 0;
        seen = 1'b0;
        bad_stall = 0;
        bad_ready = 0;
        got_rd = 'x;
        got_err = 1'bx;
        while (!seen && k < 40) begin
            @(negedge clk);
            #1;
            k++;
            if (rdy[sel] !== 1'b0) bad_ready++;
            if (rv[sel] === 1'b1) begin
                seen = 1'b1;
                got_rd = rda[sel];
                got_err = erra[sel];
                if (stl[sel] !== 1'b0) bad_stall++;
            end else if (stl[sel] !== 1'b1) begin
                bad_stall++;
            end
        end
        if (!hold) req_valid = 1'b0;
        check({tag, "_latency"}, 32'(k), 32'(lat_of(sel)));
        check({tag, "_stall_prof"}, 32'(bad_stall), 32'd0);
        check({tag, "_ready_busy"}, 32'(bad_ready), 32'd0);
        check({tag, "_err"}, 32'(got_err), 32'(exp_err));
        check({tag, "_rdata"}, got_rd, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int bad_rdy;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_ready", 32'(rdy[0]), 32'd1);
        check("rst_resp_valid", 32'(rv[0]), 32'd0);
        check("rst_rdata", rda[0], 32'h0);
        check("rst_err", 32'(erra[0]), 32'd0);
        check("rst_stall_idle", 32'(stl[0]), 32'd0);

        // LATENCY=2 basic word traffic
        sel = 0;
        access("sw10", 1, 32'h10, 32'hDEADBEEF, MODE_W, 32'h0, 0, 0);
        access("lw10", 0, 32'h10, 32'h0, MODE_W, 32'hDEADBEEF, 0, 0);
        access("lw_wrap", 0, 32'h1010, 32'h0, MODE_W, 32'hDEADBEEF, 0, 0);

        // Sub-word stores and sign/zero-extended loads
        access("sw20", 1, 32'h20, 32'h0, MODE_W, 32'h0, 0, 0);
        access("sb21", 1, 32'h21, 32'h12345680, MODE_B, 32'h0, 0, 0);
        access("lw20a", 0, 32'h20, 32'h0, MODE_W, 32'h00008000, 0, 0);
        access("lb21", 0, 32'h21, 32'h0, MODE_B, 32'hFFFFFF80, 0, 0);
        access("lbu21", 0, 32'h21, 32'h0, MODE_BU, 32'h00000080, 0, 0);
        access("sh22", 1, 32'h22, 32'hABCD8001, MODE_H, 32'h0, 0, 0);
        access("lh22", 0, 32'h22, 32'h0, MODE_H, 32'hFFFF8001, 0, 0);
        access("lhu22", 0, 32'h22, 32'h0, MODE_HU, 32'h00008001, 0, 0);
        access("sb23", 1, 32'h23, 32'h0000007F, MODE_B, 32'h0, 0, 0);
        access("lw20b", 0, 32'h20, 32'h0, MODE_W, 32'h7F018000, 0, 0);
        access("lb23", 0, 32'h23, 32'h0, MODE_B, 32'h0000007F, 0, 0);
        access("lh20", 0, 32'h20, 32'h0, MODE_H, 32'hFFFF8000, 0, 0);

        // Misaligned and illegal accesses
        access("lw13", 0, 32'h13, 32'h0, MODE_W, 32'h0, 1, 0);
        access("sw30", 1, 32'h30, 32'h11223344, MODE_W, 32'h0, 0, 0);
        access("sh31", 1, 32'h31, 32'hAAAAAAAA, MODE_H, 32'h0, 1, 0);
        access("sbu30", 1, 32'h30, 32'h55555555, MODE_BU, 32'h0, 1, 0);
        access("lw30", 0, 32'h30, 32'h0, MODE_W, 32'h11223344, 0, 0);
        access("ld011", 0, 32'h30, 32'h0, 3'b011, 32'h0, 1, 0);
        access("lh21", 0, 32'h21, 32'h0, MODE_H, 32'h0, 1, 0);
        access("lhu33", 0, 32'h33, 32'h0, MODE_HU, 32'h0, 1, 0);

        // Back-to-back with req_valid held high across all three
        access("b2b_sw", 1, 32'h50, 32'h0A0B0C0D, MODE_W, 32'h0, 0, 1);
        access("b2b_lw", 0, 32'h50, 32'h0, MODE_W, 32'h0A0B0C0D, 0, 1);
        access("b2b_lb", 0, 32'h53, 32'h0, MODE_B, 32'h0000000A, 0, 0);

        // LATENCY=1 and LATENCY=15
        sel = 1;
        access("l1_sw", 1, 32'h44, 32'hCAFEBABE, MODE_W, 32'h0, 0, 0);
        access("l1_lhu", 0, 32'h46, 32'h0, MODE_HU, 32'h0000CAFE, 0, 0);
        sel = 2;
        access("l15_sw", 1, 32'h8, 32'h01020304, MODE_W, 32'h0, 0, 0);
        access("l15_lb", 0, 32'h9, 32'h0, MODE_B, 32'h00000003, 0, 0);

        // Reset in the middle of WAIT on a LATENCY=4 store
        sel = 3;
        access("r_pre", 1, 32'h40, 32'h12345678, MODE_W, 32'h0, 0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'hCAFEF00D;
        req_mode  = MODE_W;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        pulses = 0;
        bad_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rv[3] !== 1'b0) pulses++;
            if (rdy[3] !== 1'b1) bad_rdy++;
            @(negedge clk);
        end
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (rv[3] !== 1'b0) pulses++;
            if (rdy[3] !== 1'b1) bad_rdy++;
        end
        check("rst_no_resp", 32'(pulses), 32'd0);
        check("rst_ready_after", 32'(bad_rdy), 32'd0);
        access("r_lw40", 0, 32'h40, 32'h0, MODE_W, 32'h12345678, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
